// File: rtl/imem_loader_ctrl.sv
// Byte-stream program loader for the instruction memory; stalls the core while loading.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start_i,
    input  logic [9:0]        word_count_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_stall_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam int CW = 10;
    localparam int PW = (ADDR_W > CW) ? ADDR_W : CW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       csum_q, csum_d;
    logic [CW-1:0]     count_lim;
    logic [31:0]       word_asm;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic              err_q, err_d;
`endif

    always_comb begin
        count_lim = (int'({22'd0, word_count_i}) > MEM_WORDS) ? CW'(MEM_WORDS) : word_count_i;
        word_asm  = word_q;
        word_asm[{idx_q, 3'b000} +: 8] = byte_data_i;
        last_word = (PW'(ptr_q) + PW'(1)) == PW'(count_q);
    end

    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        idx_d        = idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err_d        = err_q;
`endif
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        load_done_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    count_d = count_lim;
                    ptr_d   = '0;
                    idx_d   = '0;
                    csum_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                    state_d = (count_lim == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    word_d = word_asm;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we_o = 1'b1;
                csum_d   = csum_q + word_q;
                // The pointer holds on the final word so it never passes the last loaded address.
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    word_d = word_asm;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        err_d   = (word_asm != csum_q);
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                load_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_busy_o = (state_q != S_IDLE);
    assign cpu_stall_o = (state_q != S_IDLE);
    assign mem_addr_o  = (state_q == S_IDLE) ? fetch_addr_i : ptr_q;
    assign mem_wdata_o = (state_q == S_WRITE) ? word_q : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign load_err_o = err_q;
`else
    assign load_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed self-checking bench for imem_loader_ctrl (default parameters).
// The checksum scenario runs only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [9:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [8:0]  fetch_addr;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    imem_loader_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .word_count_i (word_count),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .fetch_addr_i (fetch_addr),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .cpu_stall_o  (cpu_stall),
        .load_busy_o  (load_busy),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Bus monitor on the falling edge, away from the active edge
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          xfer_cyc_q[$];
    int          done_cnt;
    int          hits[512];
    logic [31:0] mem_m[512];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(cyc);
                hits[mem_addr]++;
                mem_m[mem_addr] = mem_wdata;
            end
            if (byte_valid && byte_ready) xfer_cyc_q.push_back(cyc);
            if (load_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        xfer_cyc_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            hits[i]  = 0;
            mem_m[i] = 32'd0;
        end
    endtask

    task automatic start_load(input logic [9:0] wc);
        load_start = 1'b1;
        word_count = wc;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("byte_timeout", 32'(byte_ready), 32'd1);
        else step();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, gap_max));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        byte_valid = 1'b0;
        n = 0;
        while (load_busy && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(load_busy), 32'd0);
    endtask

    task automatic run_three(input int gap_max, input bit repulse);
        logic [31:0] w0, w1, w2;
        w0 = 32'h1234_5678;
        w1 = 32'hDEAD_BEEF;
        w2 = 32'h0000_0001;
        clear_log();
        start_load(10'd3);
        send_word(w0, gap_max);
        send_byte(w1[7:0], $urandom_range(0, gap_max));
        if (repulse) begin
            byte_valid = 1'b0;
            load_start = 1'b1;
            word_count = 10'd1;
            step();
            load_start = 1'b0;
        end
        send_byte(w1[15:8], $urandom_range(0, gap_max));
        send_byte(w1[23:16], $urandom_range(0, gap_max));
        send_byte(w1[31:24], $urandom_range(0, gap_max));
        send_word(w2, gap_max);
        wait_idle("three_idle");
        check("three_nwr", 32'(wr_addr_q.size()), 32'd3);
        check("three_m0", mem_m[0], w0);
        check("three_m1", mem_m[1], w1);
        check("three_m2", mem_m[2], w2);
        check("three_done", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n      = 1'b0;
        load_start = 1'b0;
        word_count = 10'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        fetch_addr = 9'h055;
        clear_log();
        #1;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h055);
        #20 rst_n = 1'b1;
        step();

        // Two words, back-to-back bytes
        clear_log();
        start_load(10'd2);
        check("recv_busy", 32'(load_busy), 32'd1);
        check("recv_stall", 32'(cpu_stall), 32'd1);
        check("recv_ready", 32'(byte_ready), 32'd1);
        check("recv_addr", 32'(mem_addr), 32'd0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_00B3, 0);
        wait_idle("two_idle");
        check("two_nwr", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 2 && xfer_cyc_q.size() >= 8) begin
            check("two_a0", 32'(wr_addr_q[0]), 32'd0);
            check("two_d0", wr_data_q[0], 32'h0000_0013);
            check("two_a1", 32'(wr_addr_q[1]), 32'd1);
            check("two_d1", wr_data_q[1], 32'h0000_00B3);
            check("two_lat0", 32'(wr_cyc_q[0] - xfer_cyc_q[3]), 32'd1);
            check("two_lat1", 32'(wr_cyc_q[1] - xfer_cyc_q[7]), 32'd1);
        end
        check("two_done", 32'(done_cnt), 32'd1);
        check("two_stall", 32'(cpu_stall), 32'd0);
        check("two_faddr", 32'(mem_addr), 32'h055);

        // Zero-length load with a byte on offer the whole time
        clear_log();
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        start_load(10'd0);
        check("zero_done", 32'(load_done), 32'd1);
        check("zero_busy", 32'(load_busy), 32'd1);
        step();
        check("zero_idle", 32'(load_busy), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("zero_nxfer", 32'(xfer_cyc_q.size()), 32'd0);
        byte_valid = 1'b0;

        // Oversized request clamps to MEM_WORDS
        clear_log();
        start_load(10'd600);
        for (int i = 0; i < 512; i++) send_word(32'hA500_0000 | 32'(i), 0);
        wait_idle("big_idle");
        check("big_nwr", 32'(wr_addr_q.size()), 32'd512);
        check("big_hit0", 32'(hits[0]), 32'd1);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (hits[i] != 1 || mem_m[i] != (32'hA500_0000 | 32'(i))) bad++;
        check("big_contents", 32'(bad), 32'd0);
        check("big_last", mem_m[511], 32'hA500_01FF);
        check("big_done", 32'(done_cnt), 32'd1);

        // Gap-free reference, then gapped run with a mid-load start pulse
        run_three(0, 1'b0);
        run_three(3, 1'b1);

        // Reset after six of eight bytes
        clear_log();
        fetch_addr = 9'h1AB;
        start_load(10'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(load_busy), 32'd0);
        check("abort_ready", 32'(byte_ready), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'h1AB);
        fetch_addr = 9'h003;
        #1;
        check("abort_follow", 32'(mem_addr), 32'h003);
        step();
        rst_n      = 1'b1;
        byte_valid = 1'b1;
        repeat (4) step();
        byte_valid = 1'b0;
        check("abort_nwr", 32'(wr_addr_q.size()), 32'd1);
        check("abort_m0", mem_m[0], 32'h4433_2211);
        check("abort_err", 32'(load_err), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_log();
        start_load(10'd2);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'h0000_0003, 0);
        wait_idle("csum_ok_idle");
        check("csum_ok_err", 32'(load_err), 32'd0);
        check("csum_ok_nwr", 32'(wr_addr_q.size()), 32'd2);
        check("csum_ok_done", 32'(done_cnt), 32'd1);
        clear_log();
        start_load(10'd2);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'h0000_0004, 0);
        wait_idle("csum_bad_idle");
        check("csum_bad_err", 32'(load_err), 32'd1);
        check("csum_bad_nwr", 32'(wr_addr_q.size()), 32'd2);
        repeat (5) step();
        check("csum_hold", 32'(load_err), 32'd1);
        start_load(10'd0);
        check("csum_clear", 32'(load_err), 32'd0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
